// File: rtl/rv_pkg.sv
// Shared RV32I front-end constants: opcodes, reset/bubble defaults and the
// per-cycle fetch update kinds.
package rv_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_R      = 5'b01100;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Which update the fetch stage performs this cycle, highest priority first
  typedef enum logic [1:0] {
    UpdFlush,
    UpdStall,
    UpdWait,
    UpdFetch
  } upd_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: instruction word to sign-extended
// immediate, selected by the major opcode in inst_i[6:2].
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [31:0] imm_o
);

  logic [4:0] op;
  logic       unused_inst_bits;

  assign op               = inst_i[6:2];
  // Low opcode bits are always 2'b11 for RV32I and carry no immediate info
  assign unused_inst_bits = ^inst_i[1:0];

  // Select the immediate format for the current opcode
  always_comb begin
    imm_o = 32'h0;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      OP_STORE:  imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      OP_BRANCH: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                          inst_i[11:8], 1'b0};
      OP_AUIPC, OP_LUI: imm_o = {inst_i[31:12], 12'b0};
      OP_JAL:    imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                          inst_i[30:21], 1'b0};
      default:   imm_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Pipeline front end: PC register, zero-latency instruction fetch, F/D register
// and field/immediate decode. Redirect beats stall beats memory wait; redirects
// and wait states inject NOP bubbles.
// Optional: define FETCH_PERF_CNT_EN to add stall/flush/wait cycle counters.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC = rv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = rv_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        next_pc_sel,
  input  logic [31:0] jb_target,
  output logic [31:0] im_addr,
  output logic        im_req,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] D_pc,
  output logic [31:0] D_inst,
  output logic [4:0]  opcode,
  output logic [2:0]  func3,
  output logic        func7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] D_imm
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_wait_cnt
`endif
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  dpc_q, dpc_d;
  logic [31:0]  inst_q, inst_d;
  rv_pkg::upd_e upd;

  // Classify this cycle's update in priority order
  always_comb begin
    if (next_pc_sel)   upd = rv_pkg::UpdFlush;
    else if (stall)    upd = rv_pkg::UpdStall;
    else if (!im_ready) upd = rv_pkg::UpdWait;
    else               upd = rv_pkg::UpdFetch;
  end

  // Next PC and F/D contents for each update kind
  always_comb begin
    pc_d   = pc_q;
    dpc_d  = dpc_q;
    inst_d = inst_q;
    unique case (upd)
      rv_pkg::UpdFlush: begin
        pc_d   = {jb_target[31:1], 1'b0};
        dpc_d  = pc_q;
        inst_d = NOP_INST;
      end
      rv_pkg::UpdStall: ;
      rv_pkg::UpdWait: begin
        dpc_d  = pc_q;
        inst_d = NOP_INST;
      end
      rv_pkg::UpdFetch: begin
        pc_d   = pc_q + 32'd4;
        dpc_d  = pc_q;
        inst_d = im_rdata;
      end
      default: ;
    endcase
  end

  // PC and F/D pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      dpc_q  <= RESET_PC;
      inst_q <= NOP_INST;
    end else begin
      pc_q   <= pc_d;
      dpc_q  <= dpc_d;
      inst_q <= inst_d;
    end
  end

  assign im_addr = pc_q;
  assign im_req  = ~rst;
  assign D_pc    = dpc_q;
  assign D_inst  = inst_q;

  assign opcode = inst_q[6:2];
  assign func3  = inst_q[14:12];
  assign func7  = inst_q[30];
  assign rs1    = inst_q[19:15];
  assign rs2    = inst_q[24:20];
  assign rd     = inst_q[11:7];

  imm_gen u_imm_gen (
    .inst_i (inst_q),
    .imm_o  (D_imm)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
      wait_cnt_q  <= 32'h0;
    end else begin
      if (upd == rv_pkg::UpdStall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (upd == rv_pkg::UpdFlush) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (upd == rv_pkg::UpdWait)  wait_cnt_q  <= wait_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
  assign perf_wait_cnt  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Self-checking bench for fetch_decode_stage: directed scenarios followed by
// randomized control inputs, compared against a behavioural model.
// Honours FETCH_PERF_CNT_EN when defined.
module tb_fetch_decode_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, next_pc_sel, im_ready, im_req, func7;
  logic [31:0] jb_target, im_addr, im_rdata, D_pc, D_inst, D_imm;
  logic [4:0]  opcode, rs1, rs2, rd;
  logic [2:0]  func3;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_wait_cnt;
`endif

  logic        ovr_en;
  logic [31:0] ovr_word;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [31:0] m_pc, m_dpc, m_inst;
  logic [31:0] m_stall_n, m_flush_n, m_wait_n;

  fetch_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .next_pc_sel (next_pc_sel),
    .jb_target   (jb_target),
    .im_addr     (im_addr),
    .im_req      (im_req),
    .im_ready    (im_ready),
    .im_rdata    (im_rdata),
    .D_pc        (D_pc),
    .D_inst      (D_inst),
    .opcode      (opcode),
    .func3       (func3),
    .func7       (func7),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .D_imm       (D_imm)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr_en) return ovr_word;
    return {a[15:0] ^ 16'hA5C3, a[15:0] + 16'h1F3};
  endfunction

  // Instruction memory answers combinationally from the presented address
  always_comb im_rdata = mem_word(im_addr);

  // Reference immediate built with signed arithmetic and shifts
  function automatic logic [31:0] imm_ref(input logic [31:0] i);
    logic signed [31:0] s;
    logic [31:0] sgn, hi20, hi25;
    s    = i;
    sgn  = s >>> 31;
    hi20 = s >>> 20;
    hi25 = s >>> 25;
    case (i[6:2])
      5'b00000, 5'b00100, 5'b11001: return hi20;
      5'b01000: return (hi25 << 5) | {27'b0, i[11:7]};
      5'b11000: return (sgn << 12) | ({31'b0, i[7]} << 11) | ({26'b0, i[30:25]} << 5)
                       | ({28'b0, i[11:8]} << 1);
      5'b00101, 5'b01101: return i & 32'hFFFF_F000;
      5'b11011: return (sgn << 20) | ({24'b0, i[19:12]} << 12) | ({31'b0, i[20]} << 11)
                       | ({22'b0, i[30:21]} << 1);
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_dpc     = 32'h0;
    m_inst    = NOP;
    m_stall_n = 0;
    m_flush_n = 0;
    m_wait_n  = 0;
  endtask

  // Apply the fetch rules to the model for one clock edge
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (next_pc_sel) begin
      m_dpc  = m_pc;
      m_inst = NOP;
      m_pc   = jb_target & ~32'h1;
      m_flush_n++;
    end else if (stall) begin
      m_stall_n++;
    end else if (!im_ready) begin
      m_dpc  = m_pc;
      m_inst = NOP;
      m_wait_n++;
    end else begin
      m_inst = mem_word(m_pc);
      m_dpc  = m_pc;
      m_pc   = m_pc + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".im_addr"}, im_addr, m_pc);
    chk({tag, ".im_req"}, {31'b0, im_req}, {31'b0, ~rst});
    chk({tag, ".D_pc"}, D_pc, m_dpc);
    chk({tag, ".D_inst"}, D_inst, m_inst);
    chk({tag, ".fields"}, {opcode, func3, func7, rs1, rs2, rd},
        {m_inst[6:2], m_inst[14:12], m_inst[30], m_inst[19:15], m_inst[24:20], m_inst[11:7]});
    chk({tag, ".D_imm"}, D_imm, imm_ref(m_inst));
`ifdef FETCH_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, perf_stall_cnt, m_stall_n);
    chk({tag, ".flush_cnt"}, perf_flush_cnt, m_flush_n);
    chk({tag, ".wait_cnt"}, perf_wait_cnt, m_wait_n);
`endif
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] imm_words [4];
    logic [31:0] imm_exp [4];
    imm_words = '{32'hFFF0_0093, 32'hFE00_0EE3, 32'h1234_50B7, 32'h0000_006F};
    imm_exp   = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h1234_5000, 32'h0000_0000};

    rst = 1'b1; stall = 1'b0; next_pc_sel = 1'b0; jb_target = 32'h0;
    im_ready = 1'b1; ovr_en = 1'b0; ovr_word = 32'h0;
    model_reset();
    #2;
    check_all("reset");
    chk("reset.opcode", {27'b0, opcode}, 32'h4);
    chk("reset.rd", {27'b0, rd}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Sequential fetch
    for (int n = 0; n < 4; n++) tick("seq");
    chk("seq.im_addr", im_addr, 32'h10);
    chk("seq.D_inst", D_inst, mem_word(32'hC));

    // Stall hold at 0x10
    stall = 1'b1;
    tick("stall"); tick("stall");
    chk("stall.im_addr", im_addr, 32'h10);
    stall = 1'b0;
    tick("resume");
    chk("resume.D_pc", D_pc, 32'h10);
    chk("resume.im_addr", im_addr, 32'h14);

    // Redirect from 0x20, then the same with stall raised
    for (int n = 0; n < 3; n++) tick("to20");
    chk("to20.im_addr", im_addr, 32'h20);
    next_pc_sel = 1'b1; jb_target = 32'h101;
    tick("redir");
    chk("redir.im_addr", im_addr, 32'h100);
    chk("redir.D_inst", D_inst, NOP);
    jb_target = 32'h20;
    tick("back20");
    stall = 1'b1; jb_target = 32'h101;
    tick("redir_stall");
    chk("redir_stall.im_addr", im_addr, 32'h100);
    chk("redir_stall.D_pc", D_pc, 32'h20);
    chk("redir_stall.D_inst", D_inst, NOP);
    stall = 1'b0;

    // Memory wait at 0x8
    jb_target = 32'h8;
    tick("to8");
    next_pc_sel = 1'b0; im_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick("wait");
      chk("wait.D_inst", D_inst, NOP);
      chk("wait.im_addr", im_addr, 32'h8);
    end
    im_ready = 1'b1;
    tick("wait_done");
    chk("wait_done.D_inst", D_inst, mem_word(32'h8));

    // Immediate decode of known encodings
    ovr_en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      ovr_word = imm_words[n];
      tick("imm");
      chk("imm.const", D_imm, imm_exp[n]);
    end
    chk("imm.rd_addi", {27'b0, rd}, 32'h0);
    ovr_word = imm_words[0];
    tick("imm_addi");
    chk("imm_addi.rd", {27'b0, rd}, 32'h1);
    ovr_en = 1'b0;

    // PC wrap
    next_pc_sel = 1'b1; jb_target = 32'hFFFF_FFFC;
    tick("to_top");
    next_pc_sel = 1'b0;
    tick("wrap");
    chk("wrap.im_addr", im_addr, 32'h0);
    chk("wrap.D_pc", D_pc, 32'hFFFF_FFFC);

    // Asynchronous reset while stalled
    stall = 1'b1;
    tick("pre_rst");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    rst = 1'b0; stall = 1'b0;

`ifdef FETCH_PERF_CNT_EN
    stall = 1'b1;
    tick("perf_s"); tick("perf_s");
    stall = 1'b0; next_pc_sel = 1'b1; jb_target = 32'h40;
    tick("perf_f");
    next_pc_sel = 1'b0; im_ready = 1'b0;
    for (int n = 0; n < 3; n++) tick("perf_w");
    im_ready = 1'b1;
    chk("perf.stall", perf_stall_cnt, 32'd2);
    chk("perf.flush", perf_flush_cnt, 32'd1);
    chk("perf.wait", perf_wait_cnt, 32'd3);
`endif

    // Randomized control traffic
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      next_pc_sel = ($urandom_range(0, 9) == 0);
      stall       = ($urandom_range(0, 6) == 0);
      im_ready    = ($urandom_range(0, 3) != 0);
      jb_target   = $urandom;
      tick("rand");
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Front end of the 5-stage RV32I pipeline: PC register, instruction-memory request, F/D pipeline register and field/immediate decode.
- Feeds opcode/func3/func7/rs1/rs2/rd and D_imm to the hazard/control unit and the D-stage datapath.
- Consumes stall (load-use) and next_pc_sel/jb_target (taken branch or jump resolved in E).
- Inserts NOP bubbles on redirect and on instruction-memory wait states.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall  in  1  load-use hazard; hold PC and F/D
- next_pc_sel  in  1  redirect request from E stage
- jb_target  in  32  redirect target; bit 0 forced to 0 internally
- im_addr  out  32  instruction memory address (= PC)
- im_req  out  1  fetch request; 1 whenever not in reset
- im_ready  in  1  im_rdata valid this cycle
- im_rdata  in  32  fetched instruction
- D_pc  out  32  PC of instruction in D
- D_inst  out  32  instruction in D
- opcode  out  5  D_inst[6:2]
- func3  out  3  D_inst[14:12]
- func7  out  1  D_inst[30]
- rs1  out  5  D_inst[19:15]
- rs2  out  5  D_inst[24:20]
- rd  out  5  D_inst[11:7]
- D_imm  out  32  sign-extended immediate of D_inst

Behaviour:
- Reset is asynchronous, active-high, on rst; clock is clk.
- Reset values: PC=RESET_PC, D_pc=RESET_PC, D_inst=NOP_INST, im_req=0. The decode outputs follow from D_inst=NOP_INST: opcode=5'b00100, rd=0, D_imm=0.
- Zero-latency fetch: im_rdata is sampled in the same cycle im_addr is presented, when im_ready=1.
- Per-cycle update, evaluated in priority order:
  1. next_pc_sel=1: PC<=jb_target&~1, D_inst<=NOP_INST, D_pc<=PC. Takes priority over stall and over im_ready=0; the fetched word is discarded.
  2. stall=1: PC, D_inst and D_pc all hold.
  3. im_ready=0: PC holds, D_inst<=NOP_INST, D_pc<=PC.
  4. Otherwise: D_inst<=im_rdata, D_pc<=PC, PC<=PC+4.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0.
- Decode fields are pure slices of D_inst; no masking by instruction type.
- D_imm by opcode:
  - I-type (00000, 00100, 11001): {{20{i[31]}},i[31:20]}.
  - S (01000): {{20{i[31]}},i[31:25],i[11:7]}.
  - B (11000): {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}.
  - U (00101, 01101): {i[31:12],12'b0}.
  - J (11011): {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}.
  - Other opcodes: 0.
- Shift-immediate instructions use D_imm[4:0]; func7 carries the arithmetic/logical bit.
- Reset asserted mid-stall or mid-wait returns everything to reset values immediately. The first fetch is at RESET_PC on the first edge after rst deasserts.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds outputs perf_stall_cnt, perf_flush_cnt and perf_wait_cnt, each 32 bits.
  - Each counts cycles in which branch 2, 1 or 3 above was taken, respectively.
  - Counters reset to 0, wrap at 2^32, and saturate nothing.
- Macro undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package rv_pkg holds:
  - Opcode constants OP_LOAD=5'b00000, OP_IMM=5'b00100, OP_STORE=5'b01000, OP_BRANCH=5'b11000, OP_JALR=5'b11001, OP_AUIPC=5'b00101, OP_LUI=5'b01101, OP_JAL=5'b11011, OP_R=5'b01100.
  - NOP_INST and RESET_PC default constants.
- One natural sub-module, imm_gen: combinational D_inst to D_imm, reusable by verification models.

Test Plan:
- Sequential fetch: rst pulse, im_ready=1, memory returns addr-dependent words -> im_addr 0,4,8,C; D_inst at cycle n equals word@4(n-1); D_pc tracks; after rst opcode=00100, rd=0.
- Stall hold: assert stall 2 cycles while PC=0x10 -> im_addr stays 0x10, D_inst/D_pc unchanged; fetch resumes at 0x10 then 0x14.
- Redirect: next_pc_sel=1, jb_target=0x101 at PC=0x20 -> next cycle im_addr=0x100, D_inst=0x00000013; the same with stall=1 concurrently gives the identical result.
- Memory wait: im_ready=0 for 3 cycles at PC=0x8 -> D_inst=NOP for 3 cycles, PC held; on im_ready=1, D_inst=word@0x8.
- Immediate decode:
  - 0xFFF00093 (addi x1,x0,-1) -> D_imm=0xFFFFFFFF, rd=1.
  - 0xFE000EE3 (beq, offset -4) -> D_imm=0xFFFFFFFC.
  - 0x123450B7 (lui) -> D_imm=0x12345000.
  - 0x0000006F (jal x0,0) -> D_imm=0.
- Wrap and perf: PC=0xFFFFFFFC with im_ready=1 -> next im_addr=0. With FETCH_PERF_CNT_EN, 2 stall, 1 flush and 3 wait cycles -> counters read 2/1/3.
